// File: rtl/ma_pkg.sv
// ma_pkg: shared definitions for the memory-access stage.
//   ma_mode_e : per-packet operation (PASS, STORE, LOAD, SWAP).
//   ma_addr() : extracts the address field from the low bits of a packet.
package ma_pkg;

  localparam int MODE_W     = 2;
  // Widest packet that ma_addr() accepts; callers widen their packet to this.
  localparam int MA_PKT_MAX = 128;

  typedef enum logic [MODE_W-1:0] {
    MA_PASS  = 2'b00,
    MA_STORE = 2'b01,
    MA_LOAD  = 2'b10,
    MA_SWAP  = 2'b11
  } ma_mode_e;

  // Returns packet[addr_w-1:0], zero-extended; the caller truncates to its ADDR_W.
  function automatic logic [MA_PKT_MAX-1:0] ma_addr(input logic [MA_PKT_MAX-1:0] packet,
                                                    input int unsigned         addr_w);
    logic [MA_PKT_MAX-1:0] mask;
    mask = (MA_PKT_MAX'(1) << addr_w) - MA_PKT_MAX'(1);
    return packet & mask;
  endfunction

endpackage

// File: rtl/ma_if.sv
// ma_if: upstream and downstream valid/ready handshakes of the memory-access stage.
//   SEND_IN/ACK_OUT           : upstream valid/ready
//   MODE, WRITE_DATA, PACKET_IN: sampled with an accepted packet
//   SEND_OUT/ACK_IN           : downstream valid/ready
//   PACKET_OUT                : result packet
// master = the neighbours driving the stage, slave = the stage itself.
interface ma_if
  import ma_pkg::*;
#(
  parameter int PKT_W  = 40,
  parameter int DATA_W = 16
);
  logic              SEND_IN;
  logic              ACK_OUT;
  logic [MODE_W-1:0] MODE;
  logic [DATA_W-1:0] WRITE_DATA;
  logic [PKT_W-1:0]  PACKET_IN;
  logic              SEND_OUT;
  logic              ACK_IN;
  logic [PKT_W-1:0]  PACKET_OUT;

  modport master (
    output SEND_IN, MODE, WRITE_DATA, PACKET_IN, ACK_IN,
    input  ACK_OUT, SEND_OUT, PACKET_OUT
  );

  modport slave (
    input  SEND_IN, MODE, WRITE_DATA, PACKET_IN, ACK_IN,
    output ACK_OUT, SEND_OUT, PACKET_OUT
  );
endinterface

// File: rtl/ma_sram.sv
// ma_sram: DEPTH x DATA_W single-port synchronous RAM, read-before-write.
//   clk     : rising-edge clock
//   en_i    : access enable (read always happens when enabled)
//   we_i    : write enable, qualified by en_i
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, old contents when reading and writing together
module ma_sram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: storage arrays get no reset so they map onto RAM macros; contents survive reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      // NOTE: non-blocking assignments make the read see the pre-write word on a swap.
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ma_stage_pipe.sv
// ma_stage_pipe: clocked memory-access stage. One op per packet (PASS, STORE,
// LOAD, SWAP), one-cycle RAM latency, full throughput via a 2-entry output FIFO.
//   CLK  : rising-edge clock
//   MR_N : asynchronous active-low master reset
//   bus  : ma_if slave port carrying both handshakes and the packet data
// Occupancy = FIFO entries + the packet in flight (accepted last edge); upstream
// is ready while occupancy < 2, from registered state only.
module ma_stage_pipe
  import ma_pkg::*;
#(
  parameter int PKT_W      = 40,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter bit STORE_DROP = 1'b0
) (
  input logic CLK,
  input logic MR_N,
  ma_if.slave bus
);

  ma_mode_e          mode;
  logic              accept;
  logic              xfer;
  logic              drop;
  logic              head_in_buf;
  logic              push;
  logic              pop;
  logic [1:0]        occ;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic [PKT_W-1:0]  fl_result;

  // In-flight slot: packet accepted on the previous edge, RAM data now valid.
  logic              fl_valid_q, fl_valid_d;
  logic              fl_load_q,  fl_load_d;
  logic [PKT_W-1:0]  fl_pkt_q,   fl_pkt_d;

  // Two-entry output FIFO.
  logic [PKT_W-1:0]  buf_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q,  count_d;

  assign mode   = ma_mode_e'(bus.MODE);
  assign addr   = ADDR_W'(ma_addr(MA_PKT_MAX'(bus.PACKET_IN), ADDR_W));
  assign occ    = count_q + {1'b0, fl_valid_q};

  assign bus.ACK_OUT = MR_N && (occ < 2'd2);
  assign accept      = bus.SEND_IN && bus.ACK_OUT;
  assign drop        = STORE_DROP && (mode == MA_STORE);

  ma_sram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk     (CLK),
    .en_i    (accept && (mode != MA_PASS)),
    .we_i    (accept && ((mode == MA_STORE) || (mode == MA_SWAP))),
    .addr_i  (addr),
    .wdata_i (bus.WRITE_DATA),
    .rdata_o (rdata)
  );

  assign fl_result = fl_load_q ? {fl_pkt_q[PKT_W-1:DATA_W], rdata} : fl_pkt_q;

  // The FIFO head is older than the in-flight packet, so it goes out first;
  // the in-flight packet bypasses the FIFO only when the FIFO is empty.
  assign head_in_buf    = (count_q != 2'd0);
  assign bus.SEND_OUT   = head_in_buf || fl_valid_q;
  assign bus.PACKET_OUT = head_in_buf ? buf_q[rd_ptr_q] :
                          (fl_valid_q ? fl_result : '0);
  assign xfer = bus.SEND_OUT && bus.ACK_IN;
  assign pop  = xfer && head_in_buf;
  // The in-flight packet is parked in the FIFO unless it left directly, so the
  // captured RAM word cannot be overwritten by the next read during a stall.
  assign push = fl_valid_q && !(xfer && !head_in_buf);

  always_comb begin
    // NOTE: every signal of this block gets a default first, so no latch is inferred.
    fl_valid_d = accept && !drop;
    fl_load_d  = fl_load_q;
    fl_pkt_d   = fl_pkt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (accept) begin
      fl_load_d = (mode == MA_LOAD) || (mode == MA_SWAP);
      fl_pkt_d  = bus.PACKET_IN;
    end
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      fl_valid_q <= 1'b0;
      fl_load_q  <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      fl_valid_q <= fl_valid_d;
      fl_load_q  <= fl_load_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload registers are qualified by the valid/count state above.
  always_ff @(posedge CLK) begin
    fl_pkt_q <= fl_pkt_d;
    if (push) buf_q[wr_ptr_q] <= fl_result;
  end

endmodule

// File: tb/tb_ma_stage_pipe.sv
// tb_ma_stage_pipe: directed bench for ma_stage_pipe. Instance a uses STORE_DROP=0,
// instance b STORE_DROP=1. A queue/array model per instance predicts outputs.
module tb_ma_stage_pipe;
  import ma_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ma_if #(.PKT_W(40), .DATA_W(16)) ia ();
  ma_if #(.PKT_W(40), .DATA_W(16)) ib ();

  ma_stage_pipe #(.PKT_W(40), .DATA_W(16), .ADDR_W(8), .STORE_DROP(1'b0)) dut_a (
    .CLK (clk), .MR_N (rst_n), .bus (ia.slave));
  ma_stage_pipe #(.PKT_W(40), .DATA_W(16), .ADDR_W(8), .STORE_DROP(1'b1)) dut_b (
    .CLK (clk), .MR_N (rst_n), .bus (ib.slave));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---- interface access by instance index ----
  function automatic logic get_ack(input bit b);  return b ? ib.ACK_OUT    : ia.ACK_OUT;    endfunction
  function automatic logic get_sout(input bit b); return b ? ib.SEND_OUT   : ia.SEND_OUT;   endfunction
  function automatic logic [39:0] get_pout(input bit b); return b ? ib.PACKET_OUT : ia.PACKET_OUT; endfunction
  function automatic logic get_sin(input bit b);  return b ? ib.SEND_IN    : ia.SEND_IN;    endfunction
  function automatic logic get_ain(input bit b);  return b ? ib.ACK_IN     : ia.ACK_IN;     endfunction
  function automatic logic [1:0]  get_mode(input bit b); return b ? ib.MODE : ia.MODE; endfunction
  function automatic logic [15:0] get_wd(input bit b);   return b ? ib.WRITE_DATA : ia.WRITE_DATA; endfunction
  function automatic logic [39:0] get_pin(input bit b);  return b ? ib.PACKET_IN  : ia.PACKET_IN;  endfunction

  task automatic drive(input bit b, input logic sv, input logic [1:0] m,
                       input logic [15:0] wd, input logic [39:0] p);
    if (b) begin ib.SEND_IN = sv; ib.MODE = m; ib.WRITE_DATA = wd; ib.PACKET_IN = p; end
    else   begin ia.SEND_IN = sv; ia.MODE = m; ia.WRITE_DATA = wd; ia.PACKET_IN = p; end
  endtask

  // Offer one packet, wait (bounded) until accepted, return at accept edge + 1.
  task automatic push(input bit b, input logic [1:0] m, input logic [15:0] wd,
                      input logic [39:0] p, output int waits);
    logic acc;
    waits = 0;
    acc   = 1'b0;
    drive(b, 1'b1, m, wd, p);
    while (!acc) begin
      acc = get_ack(b);
      @(posedge clk);
      #1;
      if (!acc) begin
        waits++;
        if (waits > 20) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout inst=%0d actual=not_accepted required=accepted", b);
          drive(b, 1'b0, 2'b00, 16'h0, 40'h0);
          return;
        end
      end
    end
    drive(b, 1'b0, 2'b00, 16'h0, 40'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---- behavioural model: memory array + FIFO of outputs owed downstream ----
  logic [15:0] mm [2][256];
  logic [39:0] fq [2][4];
  int          fcnt [2];
  bit          drop_cfg [2] = '{1'b0, 1'b1};
  logic        m_acc, m_xfer;
  logic [39:0] m_p;
  logic [15:0] m_old;
  int          m_a;

  task automatic mq_push(input int b, input logic [39:0] v);
    fq[b][fcnt[b]] = v;
    fcnt[b]++;
  endtask

  task automatic mq_pop(input int b);
    for (int j = 0; j < 3; j++) fq[b][j] = fq[b][j+1];
    fcnt[b]--;
  endtask

  always @(negedge rst_n) begin
    fcnt[0] = 0;
    fcnt[1] = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 2; b++) begin
        m_acc  = get_sin(b[0]) && (fcnt[b] < 2);
        m_xfer = (fcnt[b] > 0) && get_ain(b[0]);
        if (m_xfer) mq_pop(b);
        if (m_acc) begin
          m_p = get_pin(b[0]);
          m_a = int'(m_p[7:0]);
          case (get_mode(b[0]))
            2'b00: mq_push(b, m_p);
            2'b01: begin
              mm[b][m_a] = get_wd(b[0]);
              if (!drop_cfg[b]) mq_push(b, m_p);
            end
            2'b10: mq_push(b, {m_p[39:16], mm[b][m_a]});
            default: begin
              m_old      = mm[b][m_a];
              mm[b][m_a] = get_wd(b[0]);
              mq_push(b, {m_p[39:16], m_old});
            end
          endcase
        end
      end
    end
  end

  // ---- single compare process, mid-cycle ----
  always @(negedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 2; b++) begin
        check($sformatf("ack_out[%0d]", b), 64'(get_ack(b[0])), 64'(fcnt[b] < 2));
        check($sformatf("send_out[%0d]", b), 64'(get_sout(b[0])), 64'(fcnt[b] > 0));
        if (fcnt[b] > 0)
          check($sformatf("packet_out[%0d]", b), 64'(get_pout(b[0])), 64'(fq[b][0]));
      end
    end
  end

  int xfer_b = 0;
  always @(posedge clk) if (rst_n && ib.SEND_OUT && ib.ACK_IN) xfer_b++;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int x0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 16'h0, 40'h0);
    drive(1'b1, 1'b0, 2'b00, 16'h0, 40'h0);
    ia.ACK_IN = 1'b1;
    ib.ACK_IN = 1'b1;
    #12;
    check("rst_send_out", 64'(ia.SEND_OUT), 64'd0);
    check("rst_ack_out", 64'(ia.ACK_OUT), 64'd0);
    check("rst_packet_out", 64'(ia.PACKET_OUT), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_ack_out", 64'(ia.ACK_OUT), 64'd1);

    // Stores pass through, then load of address 3.
    push(1'b0, MA_STORE, 16'd10, 40'h00_0000_0003, w);
    push(1'b0, MA_STORE, 16'd12, 40'hFF_FFFF_0002, w);
    push(1'b0, MA_STORE, 16'd15, 40'h00_0000_0001, w);
    push(1'b0, MA_LOAD,  16'd0,  40'hFF_FFFF_0003, w);
    check("load3_send", 64'(ia.SEND_OUT), 64'd1);
    check("load3_value", 64'(ia.PACKET_OUT), 64'hFF_FFFF_000A);
    idle(2);

    // Store at k, load of the same address at k+1.
    push(1'b0, MA_STORE, 16'hABCD, 40'h00_0000_0005, w);
    push(1'b0, MA_LOAD,  16'd0,    40'h12_3456_0005, w);
    check("store_load_fwd", 64'(ia.PACKET_OUT), 64'h12_3456_ABCD);
    idle(2);

    // Swap returns old word, later load sees new word.
    push(1'b0, MA_STORE, 16'd4, 40'h00_0000_0007, w);
    push(1'b0, MA_SWAP,  16'd9, 40'h00_0000_0007, w);
    check("swap_old", 64'(ia.PACKET_OUT), 64'h00_0000_0004);
    push(1'b0, MA_LOAD,  16'd0, 40'h00_0000_0007, w);
    check("swap_new", 64'(ia.PACKET_OUT), 64'h00_0000_0009);
    idle(2);

    // Back-to-back loads under a 4-cycle downstream stall.
    ia.ACK_IN = 1'b0;
    fork
      begin
        push(1'b0, MA_LOAD, 16'd0, 40'h00_0000_0001, w);
        push(1'b0, MA_LOAD, 16'd0, 40'h00_0000_0002, w);
        check("stall_ack_drop", 64'(ia.ACK_OUT), 64'd0);
        push(1'b0, MA_LOAD, 16'd0, 40'h00_0000_0003, w);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("stall_hold_send", 64'(ia.SEND_OUT), 64'd1);
        check("stall_hold_pkt", 64'(ia.PACKET_OUT), 64'h00_0000_000F);
        @(posedge clk); #1;
        ia.ACK_IN = 1'b1;
      end
    join
    idle(3);

    // Full throughput with both sides streaming.
    for (int i = 0; i < 6; i++) begin
      push(1'b0, MA_PASS, 16'd0, 40'hA0_0000_0000 + 40'(i), w);
      check("throughput_wait", 64'(w), 64'd0);
    end
    idle(3);

    // STORE_DROP=1 instance: PASS, STORE, PASS gives two transfers.
    x0 = xfer_b;
    push(1'b1, MA_PASS,  16'd0,     40'h55_0000_0001, w);
    push(1'b1, MA_STORE, 16'h5A5A,  40'h55_0000_0009, w);
    push(1'b1, MA_PASS,  16'd0,     40'h55_0000_0002, w);
    idle(3);
    check("drop_xfer_count", 64'(xfer_b - x0), 64'd2);
    push(1'b1, MA_LOAD, 16'd0, 40'h77_0000_0009, w);
    check("drop_store_written", 64'(ib.PACKET_OUT), 64'h77_0000_5A5A);
    idle(2);

    // Reset mid-transfer with the stage full.
    ia.ACK_IN = 1'b0;
    push(1'b0, MA_PASS, 16'd0, 40'h11_1111_1111, w);
    push(1'b0, MA_PASS, 16'd0, 40'h22_2222_2222, w);
    check("full_before_rst", 64'({ia.SEND_OUT, ia.ACK_OUT}), 64'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_send_out", 64'(ia.SEND_OUT), 64'd0);
    check("async_ack_out", 64'(ia.ACK_OUT), 64'd0);
    check("async_packet_out", 64'(ia.PACKET_OUT), 64'd0);
    ia.ACK_IN = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rerelease_ack", 64'(ia.ACK_OUT), 64'd1);
    idle(2);
    check("no_stale_packet", 64'(ia.SEND_OUT), 64'd0);
    push(1'b0, MA_LOAD, 16'd0, 40'h00_0000_0002, w);
    check("mem_kept", 64'(ia.PACKET_OUT), 64'h00_0000_000C);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
